// File: rtl/cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cmd_ctrl_pkg
// Shared definitions for the command controller: FSM state encoding, command
// opcodes and the register-file addresses used for ALU operands.
// -----------------------------------------------------------------------------
package cmd_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        WR_EXEC  = 4'd3,
        RD_ADDR  = 4'd4,
        RD_WAIT  = 4'd5,
        RD_TX    = 4'd6,
        OPA      = 4'd7,
        OPA_WR   = 4'd8,
        OPB      = 4'd9,
        OPB_WR   = 4'd10,
        FUN      = 4'd11,
        ALU_WAIT = 4'd12,
        ALU_TX   = 4'd13
    } state_e;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    // States that are waiting for the next byte of a frame; only these can
    // be aborted by the inter-byte timeout.
    function automatic logic is_frame_wait(input state_e s);
        return s inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN};
    endfunction

endpackage

// File: rtl/cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// cmd_ctrl_if
// Bundle of every controller-facing signal: UART RX byte stream, ALU result
// and control, register-file port, TX FIFO push port and frame-error flag.
//   master : the controller (drives ALU/regfile/FIFO controls)
//   slave  : the surrounding system (drives RX bytes, results, FIFO_FULL)
// -----------------------------------------------------------------------------
interface cmd_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4
) ();

    logic [DATA_W-1:0]   RX_P_DATA;
    logic                RX_D_VLD;
    logic [2*DATA_W-1:0] ALU_OUT;
    logic                OUT_Valid;
    logic [DATA_W-1:0]   RdData;
    logic                RdData_Valid;
    logic                FIFO_FULL;
    logic [FUN_W-1:0]    ALU_FUN;
    logic                ALU_EN;
    logic                CLK_EN;
    logic [ADDR_W-1:0]   Address;
    logic                WrEn;
    logic                RdEn;
    logic [DATA_W-1:0]   WrData;
    logic                clk_div_en;
    logic [DATA_W-1:0]   FIFO_Wr_Data;
    logic                FIFO_Wr_INC;
    logic                Frame_Err;

    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, RdData, RdData_Valid, FIFO_FULL,
        output ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData, clk_div_en,
               FIFO_Wr_Data, FIFO_Wr_INC, Frame_Err
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, RdData, RdData_Valid, FIFO_FULL,
        input  ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData, clk_div_en,
               FIFO_Wr_Data, FIFO_Wr_INC, Frame_Err
    );

endinterface

// File: rtl/cmd_ctrl_timer.sv
// -----------------------------------------------------------------------------
// cmd_ctrl_timer
// Clearable saturating up-counter with a terminal flag.
//   CLK, RST : clock, asynchronous active-low reset
//   clr_i    : synchronous clear (wins over count)
//   en_i     : count enable
//   term_o   : count has reached TERM (counter holds there)
// -----------------------------------------------------------------------------
module cmd_ctrl_timer #(
    parameter int TERM = 1023
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CW = $clog2(TERM + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == CW'(TERM));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !term_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cmd_ctrl.sv
// -----------------------------------------------------------------------------
// cmd_ctrl
// Byte-framed command decoder: register write (AA addr data), register read
// (BB addr), ALU with operands (CC opa opb fun), ALU without operands
// (DD fun). Drives the register file and gated ALU and pushes read data /
// RES_BYTES ALU result bytes (LSB first) into the TX FIFO.
// Ports:
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : cmd_ctrl_if.master (RX bytes, ALU, regfile, TX FIFO, Frame_Err)
// Build option: define CMD_CTRL_TIMEOUT_EN to abort a frame whose next byte
// does not arrive within TIMEOUT_CYC cycles (pulses Frame_Err). Without it
// Frame_Err is tied low and a frame waits indefinitely.
// -----------------------------------------------------------------------------
module cmd_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int FUN_W       = 4,
    parameter int RES_BYTES   = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic       CLK,
    input  logic       RST,
    cmd_ctrl_if.master bus
);

    import cmd_ctrl_pkg::*;

    localparam logic LAST_IDX = 1'(RES_BYTES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [FUN_W-1:0]    fun_q, fun_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic [2*DATA_W-1:0] res_q, res_d;
    logic                idx_q, idx_d;
    logic                timeout;

    logic [FUN_W-1:0]    alu_fun;
    logic                alu_en;
    logic [ADDR_W-1:0]   address;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   fifo_data;
    logic                fifo_inc;

`ifdef CMD_CTRL_TIMEOUT_EN
    logic frame_wait;
    logic tmr_clr;
    logic tmr_term;

    // Restart the gap count on every byte and on every state change so each
    // waiting state gets a full TIMEOUT_CYC window.
    assign frame_wait = is_frame_wait(state_q);
    assign tmr_clr    = bus.RX_D_VLD || (state_d != state_q) || !frame_wait;

    cmd_ctrl_timer #(.TERM(TIMEOUT_CYC)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clr_i  (tmr_clr),
        .en_i   (frame_wait),
        .term_o (tmr_term)
    );

    assign timeout = frame_wait && tmr_term;
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every variable written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fun_d     = fun_q;
        rd_d      = rd_q;
        res_d     = res_q;
        idx_d     = idx_q;
        alu_fun   = '0;
        alu_en    = 1'b0;
        address   = '0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_data   = '0;
        fifo_data = '0;
        fifo_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if      (bus.RX_P_DATA == DATA_W'(CMD_WR))      state_d = WR_ADDR;
                    else if (bus.RX_P_DATA == DATA_W'(CMD_RD))      state_d = RD_ADDR;
                    else if (bus.RX_P_DATA == DATA_W'(CMD_ALU_OP))  state_d = OPA;
                    else if (bus.RX_P_DATA == DATA_W'(CMD_ALU_NOP)) state_d = FUN;
                end
            end
            WR_ADDR: if (bus.RX_D_VLD) begin
                addr_d  = bus.RX_P_DATA[ADDR_W-1:0];
                state_d = WR_DATA;
            end
            WR_DATA: if (bus.RX_D_VLD) begin
                wdata_d = bus.RX_P_DATA;
                state_d = WR_EXEC;
            end
            WR_EXEC: begin
                wr_en   = 1'b1;
                address = addr_q;
                wr_data = wdata_q;
                state_d = IDLE;
            end
            RD_ADDR: if (bus.RX_D_VLD) begin
                addr_d  = bus.RX_P_DATA[ADDR_W-1:0];
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rd_en   = 1'b1;
                address = addr_q;
                if (bus.RdData_Valid) begin
                    rd_d    = bus.RdData;
                    state_d = RD_TX;
                end
            end
            RD_TX: begin
                fifo_data = rd_q;
                if (!bus.FIFO_FULL) begin
                    fifo_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            OPA: if (bus.RX_D_VLD) begin
                wdata_d = bus.RX_P_DATA;
                state_d = OPA_WR;
            end
            OPA_WR: begin
                wr_en   = 1'b1;
                address = ADDR_W'(OPA_ADDR);
                wr_data = wdata_q;
                state_d = OPB;
            end
            OPB: if (bus.RX_D_VLD) begin
                wdata_d = bus.RX_P_DATA;
                state_d = OPB_WR;
            end
            OPB_WR: begin
                wr_en   = 1'b1;
                address = ADDR_W'(OPB_ADDR);
                wr_data = wdata_q;
                state_d = FUN;
            end
            FUN: if (bus.RX_D_VLD) begin
                fun_d   = bus.RX_P_DATA[FUN_W-1:0];
                state_d = ALU_WAIT;
            end
            ALU_WAIT: begin
                alu_en  = 1'b1;
                alu_fun = fun_q;
                if (bus.OUT_Valid) begin
                    res_d   = bus.ALU_OUT;
                    idx_d   = 1'b0;
                    state_d = ALU_TX;
                end
            end
            ALU_TX: begin
                fifo_data = idx_q ? res_q[2*DATA_W-1:DATA_W] : res_q[DATA_W-1:0];
                // The byte index only moves on an accepted push, so a full
                // FIFO simply repeats the same byte on a later cycle.
                if (!bus.FIFO_FULL) begin
                    fifo_inc = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            fun_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            idx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fun_q   <= fun_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.ALU_FUN      = alu_fun;
    assign bus.ALU_EN       = alu_en;
    assign bus.CLK_EN       = alu_en;
    assign bus.Address      = address;
    assign bus.WrEn         = wr_en;
    assign bus.RdEn         = rd_en;
    assign bus.WrData       = wr_data;
    assign bus.clk_div_en   = 1'b1;
    assign bus.FIFO_Wr_Data = fifo_data;
    assign bus.FIFO_Wr_INC  = fifo_inc;
    assign bus.Frame_Err    = timeout;

endmodule
